// File: rtl/relax_osc_pkg.sv
// Shared definitions for the relaxation-oscillator trim calibration block.
package relax_osc_pkg;

  localparam int unsigned DEF_TRIM_W     = 6;
  localparam int unsigned DEF_CNT_W      = 12;
  localparam int unsigned DEF_WIN_W      = 10;
  localparam int unsigned DEF_SETTLE_CYC = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DECIDE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/relax_osc_edge_counter.sv
// Synchronises the raw oscillator, detects rising edges and counts them
// (saturating) while enabled; clr zeroes the count for a new window.
module relax_osc_edge_counter #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic sync1, sync2, sync3;
  logic rise;

  assign rise = sync2 & ~sync3;

  // Synchroniser runs in every state so the history is valid at window start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      count <= '0;
    end else begin
      sync1 <= osc_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (clr)
        count <= '0;
      else if (en && rise && (count != '1))
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/relax_osc_trim_ctrl.sv
// SAR calibration of the relaxation oscillator trim: finds the largest trim
// code whose edge count over the measurement window does not exceed target.
module relax_osc_trim_ctrl
  import relax_osc_pkg::*;
#(
  parameter int unsigned TRIM_W     = DEF_TRIM_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned WIN_W      = DEF_WIN_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [CNT_W-1:0]  target,
  input  logic              osc_in,
  output logic [TRIM_W-1:0] trim,
  output logic              osc_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  meas_count
);

  localparam int unsigned IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [TRIM_W-1:0] TRIM_MSB = TRIM_W'(1) << (TRIM_W - 1);

  state_t            state;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  idx_dn;
  logic [7:0]        settle_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [WIN_W-1:0]  win_load;
  logic [CNT_W-1:0]  edge_count;
  logic              cnt_clr;
  logic              cnt_en;

  assign osc_en   = run | busy;
  assign idx_dn   = bit_idx - 1'b1;
  assign win_load = (win_len == '0) ? '0 : win_len - 1'b1;
  // Clear on the last settle cycle so the count is zero on the first window cycle.
  assign cnt_clr  = (state == ST_SETTLE) && (settle_cnt == '0);
  assign cnt_en   = (state == ST_MEASURE);

  relax_osc_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_cnt (
    .clk    (clk),
    .rst    (rst),
    .osc_in (osc_in),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (edge_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      trim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      meas_count <= '0;
      bit_idx    <= '0;
      settle_cnt <= '0;
      win_cnt    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SETTLE;
            busy       <= 1'b1;
            bit_idx    <= IDX_W'(TRIM_W - 1);
            trim       <= TRIM_MSB;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state   <= ST_MEASURE;
            win_cnt <= win_load;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_MEASURE: begin
          if (win_cnt == '0)
            state <= ST_DECIDE;
          else
            win_cnt <= win_cnt - 1'b1;
        end
        ST_DECIDE: begin
          meas_count <= edge_count;
          if (edge_count > target)
            trim[bit_idx] <= 1'b0;
          if (bit_idx == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            bit_idx      <= idx_dn;
            trim[idx_dn] <= 1'b1;
            settle_cnt   <= SETTLE_LOAD;
            state        <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relax_osc_trim_ctrl.sv
// Directed bench for relax_osc_trim_ctrl: vector table plus multi-cycle sequences.
module tb_relax_osc_trim_ctrl;

  localparam int TW = 6;
  localparam int CW = 12;
  localparam int WW = 10;
  localparam int SC = 4;

  localparam int M_CONST  = 0;
  localparam int M_TOGGLE = 1;
  localparam int M_PULSE  = 2;

  typedef struct {
    int wl;
    int tg;
    int mode;
    int extra;
    int exp_trim;
    int exp_meas;
    int exp_lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start, run, osc_in;
  logic [WW-1:0] win_len;
  logic [CW-1:0] target;
  logic [TW-1:0] trim;
  logic          osc_en, busy, done;
  logic [CW-1:0] meas_count;

  logic          s_start, s_osc, s_osc_en, s_busy, s_done;
  logic [WW-1:0] s_win;
  logic [3:0]    s_target, s_meas;
  logic [2:0]    s_trim;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relax_osc_trim_ctrl #(
    .TRIM_W(TW), .CNT_W(CW), .WIN_W(WW), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .run(run), .win_len(win_len),
    .target(target), .osc_in(osc_in), .trim(trim), .osc_en(osc_en),
    .busy(busy), .done(done), .meas_count(meas_count)
  );

  relax_osc_trim_ctrl #(
    .TRIM_W(3), .CNT_W(4), .WIN_W(WW), .SETTLE_CYC(SC)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .run(1'b0), .win_len(s_win),
    .target(s_target), .osc_in(s_osc), .trim(s_trim), .osc_en(s_osc_en),
    .busy(s_busy), .done(s_done), .meas_count(s_meas)
  );

  initial begin
    s_osc = 1'b0;
    forever begin
      @(negedge clk);
      s_osc = ~s_osc;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One calibration; lat counts cycles from the start-sampling cycle to done.
  task automatic run_cal(input vec_t v, output int lat, output bit en_ok);
    int t0;
    int p;
    bit fin;
    p = SC + ((v.wl == 0) ? 1 : v.wl) + 1;
    win_len = WW'(v.wl);
    target  = CW'(v.tg);
    osc_in  = 1'b0;
    lat     = -1;
    fin     = 1'b0;
    en_ok   = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    fork
      begin
        for (int j = 0; j < 4000; j++) begin
          start = (v.extra != 0) && (j == 50);
          if (busy && !osc_en) en_ok = 1'b0;
          if (done) begin
            lat = j + 1;
            break;
          end
          @(negedge clk);
        end
        start = 1'b0;
        fin = 1'b1;
      end
      begin
        if (v.mode == M_PULSE) begin
          for (int b = 0; b < TW; b++) begin
            while ((cyc - t0 < b * p + 6) && !fin) @(negedge clk);
            // Oscillator model: trim + 4 rising edges per window.
            for (int i = 0; i < int'(trim) + 4 && !fin; i++) begin
              osc_in = 1'b1;
              @(negedge clk);
              osc_in = 1'b0;
              @(negedge clk);
            end
          end
        end else if (v.mode == M_TOGGLE) begin
          while (!fin) begin
            osc_in = ~osc_in;
            @(negedge clk);
          end
        end
      end
    join
    osc_in = 1'b0;
  endtask

  initial begin
    vec_t vecs[9];
    int   lat, j1, j2, t0;
    bit   ok, seen;

    vecs[0] = '{wl: 150, tg: 34,  mode: M_PULSE,  extra: 0, exp_trim: 30, exp_meas: 35, exp_lat: 931};
    vecs[1] = '{wl: 150, tg: 36,  mode: M_PULSE,  extra: 0, exp_trim: 32, exp_meas: 37, exp_lat: 931};
    vecs[2] = '{wl: 150, tg: 130, mode: M_PULSE,  extra: 0, exp_trim: 63, exp_meas: 67, exp_lat: 931};
    vecs[3] = '{wl: 150, tg: 3,   mode: M_PULSE,  extra: 0, exp_trim: 0,  exp_meas: 5,  exp_lat: 931};
    vecs[4] = '{wl: 20,  tg: 0,   mode: M_TOGGLE, extra: 0, exp_trim: 0,  exp_meas: -1, exp_lat: 151};
    vecs[5] = '{wl: 20,  tg: 0,   mode: M_CONST,  extra: 0, exp_trim: 63, exp_meas: 0,  exp_lat: 151};
    vecs[6] = '{wl: 0,   tg: 0,   mode: M_CONST,  extra: 0, exp_trim: 63, exp_meas: 0,  exp_lat: 37};
    vecs[7] = '{wl: 1,   tg: 0,   mode: M_CONST,  extra: 0, exp_trim: 63, exp_meas: 0,  exp_lat: 37};
    vecs[8] = '{wl: 150, tg: 34,  mode: M_PULSE,  extra: 1, exp_trim: 30, exp_meas: 35, exp_lat: 931};

    rst = 1'b1; start = 1'b0; run = 1'b0; osc_in = 1'b0;
    win_len = '0; target = '0;
    s_start = 1'b0; s_win = WW'(60); s_target = 4'd15;
    repeat (2) @(negedge clk);
    check("reset trim", trim, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset meas_count", meas_count, 0);
    check("reset osc_en", osc_en, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      run_cal(vecs[k], lat, ok);
      check($sformatf("v%0d latency", k), lat, vecs[k].exp_lat);
      check($sformatf("v%0d trim", k), trim, vecs[k].exp_trim);
      if (vecs[k].exp_meas >= 0)
        check($sformatf("v%0d meas_count", k), meas_count, vecs[k].exp_meas);
      check($sformatf("v%0d osc_en while busy", k), ok, 1);
      @(negedge clk);
      check($sformatf("v%0d done one cycle", k), done, 0);
      check($sformatf("v%0d busy after done", k), busy, 0);
      repeat (3) @(negedge clk);
    end

    // Saturation on a 4-bit counter instance: ~30 edges per window clip to 15.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    lat = -1;
    for (int j = 0; j < 500; j++) begin
      if (s_done) begin
        lat = j + 1;
        break;
      end
      @(negedge clk);
    end
    check("sat latency", lat, 1 + 3 * (SC + 60 + 1));
    check("sat meas_count", s_meas, 15);
    check("sat trim", s_trim, 7);
    repeat (3) @(negedge clk);

    // start held high: second run is sampled in the IDLE cycle after DONE.
    win_len = '0; target = '0; osc_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    j1 = -1; j2 = -1;
    for (int j = 0; j < 200; j++) begin
      if (done && j1 < 0) j1 = j;
      else if (done && j2 < 0) begin
        j2 = j;
        start = 1'b0;
        break;
      end
      if (j1 >= 0 && j == j1 + 1) check("held start idle busy", busy, 0);
      if (j1 >= 0 && j == j1 + 2) check("held start restart busy", busy, 1);
      @(negedge clk);
    end
    start = 1'b0;
    check("held start first done", j1 + 1, 37);
    check("held start second done gap", j2 - j1, 38);
    check("held start trim", trim, 63);
    repeat (4) @(negedge clk);

    // Reset during the third MEASURE window aborts the run.
    win_len = WW'(10); target = CW'(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    while (cyc - t0 < 36) begin
      osc_in = ~osc_in;
      @(negedge clk);
    end
    check("pre-reset meas_count nonzero", (meas_count != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    osc_in = 1'b0;
    check("mid reset trim", trim, 0);
    check("mid reset busy", busy, 0);
    check("mid reset meas_count", meas_count, 0);
    check("mid reset osc_en run=0", osc_en, 0);
    run = 1'b1;
    #1;
    check("mid reset osc_en run=1", osc_en, 1);
    run = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("no done after reset", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
